// File: rtl/em_counter_n_if.sv
// Control/status bundle for em_counter_n: the counter drives count/tc/rco,
// and everything else comes from the controlling side.
interface em_counter_n_if #(
  parameter int WIDTH = 4
);
  logic             nsclr;
  logic             nload;
  logic             ent;
  logic             enp;
  logic             up;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             rco;

  modport master (
    output nsclr, nload, ent, enp, up, parallel_in,
    input  count, tc, rco
  );

  modport slave (
    input  nsclr, nload, ent, enp, up, parallel_in,
    output count, tc, rco
  );
endinterface

// File: rtl/em_counter_n.sv
// Presettable modulo-N up/down counter with synchronous clear, parallel load
// and a direction-aware terminal count for rco cascading.
module em_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic         clk,
  input  logic         nclr,
  em_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             tc_int;

  always_comb begin
    count_next = count_reg;
    if (!bus.nsclr) begin
      count_next = '0;
    end else if (!bus.nload) begin
      count_next = bus.parallel_in;
    end else if (bus.ent && bus.enp) begin
      if (bus.up) begin
        // Anything at or past the last legal value (e.g. a raw load) wraps to 0.
        count_next = (count_reg >= LAST) ? '0 : count_reg + 1'b1;
      end else begin
        count_next = (count_reg == '0) ? LAST : count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // tc/rco stay combinational so a cascade enables the next stage in the same cycle.
  assign tc_int    = bus.up ? (count_reg == LAST) : (count_reg == '0);
  assign bus.count = count_reg;
  assign bus.tc    = tc_int;
  assign bus.rco   = tc_int & bus.ent;

endmodule

// File: doc/em_counter_n.md
# em_counter_n

Parametrised synchronous presettable counter. It generalises the 4-bit binary up counter to any width and modulus, with up/down counting, synchronous clear, and a direction-aware terminal count. It is the building block for the EDUC-8 program counter, the cycle/step sequencer and the BCD display counters. Instances cascade through `rco` into the next stage's `ent`/`enp`.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 1..16.
- `MODULUS`, default 16: count length. Legal range 2..2^WIDTH. Use 10 for a 74160/74190-style decade counter.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `nclr`  in  1: asynchronous active-low reset; forces `count` to 0 immediately.
- `nsclr`  in  1: synchronous active-low clear (74163-style).
- `nload`  in  1: synchronous active-low parallel load.
- `ent`  in  1: count enable T; also gates `rco`.
- `enp`  in  1: count enable P.
- `up`  in  1: direction; 1 = up, 0 = down.
- `parallel_in`  in  WIDTH: load value.
- `count`  out  WIDTH: current count, registered.
- `tc`  out  1: terminal count, combinational.
- `rco`  out  1: ripple carry/borrow out, combinational.

## Operation
- Reset: while `nclr`=0, `count`=0 regardless of `clk`. `tc` and `rco` follow their equations from `count`=0.
- Priority at each rising `clk` edge when `nclr`=1, highest first:
  1. `nsclr`=0 → `count` ← 0.
  2. `nload`=0 → `count` ← `parallel_in`. The raw value is loaded, even if it is ≥ `MODULUS`.
  3. `ent`=1 and `enp`=1 with `up`=1:
     - `count` ≥ `MODULUS`-1 → `count` ← 0.
     - otherwise `count` ← `count`+1.
  4. `ent`=1 and `enp`=1 with `up`=0:
     - `count`=0 → `count` ← `MODULUS`-1.
     - otherwise `count` ← `count`-1.
  5. Otherwise `count` holds.
- Out-of-range values are values ≥ `MODULUS`, reachable only by load:
  - Counting up returns to 0 on the next enabled edge.
  - Counting down decrements normally until the value is back in range.
- Terminal count: `tc` = (`up` & `count`==`MODULUS`-1) | (~`up` & `count`==0).
- Ripple carry: `rco` = `tc` & `ent`. It does not depend on `enp`.
- Cascading: connect stage N `rco` to stage N+1 `ent` and `enp`, and share `clk`, `nclr` and `up`. The chain then behaves as one counter of the product modulus.
- Arithmetic is WIDTH bits, unsigned; the wrap target is `MODULUS`, not 2^WIDTH.
- Sequential logic has no gate delays; only the primitive gates model delays.

## Timing
- Registered outputs: `count` changes only on a rising `clk` edge, or asynchronously on `nclr` falling.
- Latency: one cycle from a sampled `nsclr`, `nload`, `ent`, `enp` or `up` to the new `count`.
- `tc` and `rco` are zero-latency combinational outputs. They update in the same cycle that `count`, `up` or `ent` changes.
- Asserting `nclr` mid-count overrides a concurrent load or count on that edge.
- Releasing `nclr` concurrently with a rising `clk` edge is not required to count.
- `up` is sampled with the counting edge. Changing `up` while at terminal count changes `tc` within the same cycle, with no spurious count.
- `nsclr`=0 and `nload`=0 together: clear wins.
- `nload`=0 with `ent`=`enp`=1: load wins; no increment occurs on that edge.

## Test plan
- Reset mid-count: WIDTH=4, MODULUS=16, `up`=1, count to 7, then pulse `nclr` low between edges → `count`=0 immediately. The next enabled edge gives 1.
- Decade up wrap: MODULUS=10, `up`=1, `ent`=`enp`=1 from 0:
  - Expected sequence 0..9, then 0.
  - `tc`=`rco`=1 only while `count`=9.
  - With `ent`=0 at 9, `rco`=0 and `tc`=1.
- Down wrap and out-of-range: MODULUS=10, `up`=0.
  - Load 0, then enable → 9, then 8.
  - Load 12 (`4'hC`) with `up`=1 → next edge gives 0.
  - Load 12 with `up`=0 → next edges give 11, 10, then 9.
- Priority: at one edge, `nsclr`=0, `nload`=0, `parallel_in`=5, `ent`=`enp`=1 → `count`=0. The next edge with only `nload`=0 gives 5, with no increment.
- Cascade: two WIDTH=4 instances chained via `rco`, loaded to 0xFE, `up`=1.
  - Expected sequence 0xFE → 0xFF → 0x00; high-stage `rco`=1 only at 0xFF.
  - With `up`=0, 0x00 → 0xFF.
- Hold: `enp`=0 with `ent`=1 at count 15 (MODULUS=16) → `count` holds at 15 and `rco`=1 throughout.
